// File: rtl/jpeg_coef_pkg.sv
// ============================================================================
// Module      : jpeg_coef_pkg
// Description : Shared defaults, DCT coefficient tables and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_coef_pkg;

    localparam int COEF_W_DEF  = 11;
    localparam int ADDR_W_DEF  = 4;
    localparam int TABLE_DEPTH = 16;

    localparam int BANK0_TABLE [TABLE_DEPTH] = '{
        502, 425, 284, 36, -99, 362, 362, 362,
        362, 362, 362, 362, 362, 362, 362, 362
    };
    localparam int BANK1_TABLE [TABLE_DEPTH] = '{default: 362};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Banks beyond the tabulated ones, and addresses beyond the tables, read 0.
    function automatic int coef_value(input int bank, input int addr);
        logic [3:0] idx;
        int         value;
        idx   = addr[3:0];
        value = 0;
        if (addr >= 0 && addr < TABLE_DEPTH) begin
            if (bank == 0) begin
                value = BANK0_TABLE[idx];
            end else if (bank == 1) begin
                value = BANK1_TABLE[idx];
            end
        end
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coef_rom_bank.sv
// ============================================================================
// Module      : coef_rom_bank
// Description : Registered single-port coefficient ROM, one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_rom_bank
    import jpeg_coef_pkg::*;
#(
    parameter int COEF_W   = COEF_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BANK_IDX = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [COEF_W-1:0] data
);

    logic [COEF_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            r_data <= COEF_W'(coef_value(BANK_IDX, int'(addr)));
        end
    end

    assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/coef_rom_streamer.sv
// ============================================================================
// Module      : coef_rom_streamer
// Description : Multi-bank coefficient ROM with random-access port and a
//               flow-controlled burst streamer with optional sign mirroring.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_rom_streamer
    import jpeg_coef_pkg::*;
#(
    parameter  int COEF_W    = COEF_W_DEF,
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int NUM_BANKS = 2,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [COEF_W-1:0] data_out,
    input  logic              start,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              mirror,
    output logic [COEF_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam logic [COEF_W-1:0] COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};
    localparam logic [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [BANK_W-1:0] r_bank;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_mirror;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [COEF_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic              r_head;
    logic [1:0]        r_count;

    logic [COEF_W-1:0] w_rom_q [NUM_BANKS];
    logic [COEF_W-1:0] w_rd_data;
    logic [COEF_W-1:0] w_push_data;
    logic [2:0]        w_slots;
    logic              w_pop;
    logic              w_issue;
    logic              w_accept;
    logic              w_tail;
    logic              w_final_read;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        coef_rom_bank #(
            .COEF_W   (COEF_W),
            .ADDR_W   (ADDR_W),
            .BANK_IDX (i)
        ) u_rom (
            .clk  (clk),
            .rst  (rst),
            .addr (r_addr),
            .data (w_rom_q[i])
        );
    end

    coef_rom_bank #(
        .COEF_W   (COEF_W),
        .ADDR_W   (ADDR_W),
        .BANK_IDX (0)
    ) u_ra_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data_out)
    );

    assign out_valid    = (r_count != 2'd0);
    assign out_data     = r_buf_data[r_head];
    assign out_last     = r_buf_last[r_head] & out_valid;
    assign busy         = (r_state != IDLE);
    assign w_pop        = out_valid & out_ready;
    assign w_tail       = r_head ^ r_count[0];
    assign w_final_read = (r_remaining == (ADDR_W+1)'(1));

    // Buffer occupancy after this cycle's pop, counting the read already in flight.
    assign w_slots = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == RUN) && (w_slots < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (length != '0)) begin
                    w_state_next = RUN;
                    w_accept     = 1'b1;
                end
            end
            RUN: begin
                if (w_issue && w_final_read) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && out_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank          <= '0;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_mirror        <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_final_read;
            if (w_accept) begin
                r_bank      <= bank_sel;
                r_addr      <= start_addr;
                r_remaining <= length;
                r_mirror    <= mirror;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_bank == BANK_W'(i)) begin
                w_rd_data = w_rom_q[i];
            end
        end
        w_push_data = w_rd_data;
        if (r_mirror) begin
            w_push_data = (w_rd_data == COEF_MIN) ? COEF_MAX : (~w_rd_data + COEF_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= '0;
            r_head        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_buf_data[w_tail] <= w_push_data;
                r_buf_last[w_tail] <= r_inflight_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_coef_rom_streamer.sv
// ============================================================================
// Module      : tb_coef_rom_streamer
// Description : Self-checking bench: behavioural stream model plus directed
//               literal expectations and randomized bursts/backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coef_rom_streamer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         addr = '0;
    logic signed [10:0] data_out;
    logic               start = 1'b0;
    logic [0:0]         bank_sel = '0;
    logic [3:0]         start_addr = '0;
    logic [4:0]         length = '0;
    logic               mirror = 1'b0;
    logic signed [10:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_last;
    logic               busy;

    always #5 clk = ~clk;

    coef_rom_streamer #(
        .COEF_W    (11),
        .ADDR_W    (4),
        .NUM_BANKS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_out   (data_out),
        .start      (start),
        .bank_sel   (bank_sel),
        .start_addr (start_addr),
        .length     (length),
        .mirror     (mirror),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    typedef struct {
        int data;
        bit last;
    } word_t;

    word_t exp_q[$];
    int    got_q[$];
    bit    got_last_q[$];
    int    ref_list[$];
    int    n_checks   = 0;
    int    n_pass     = 0;
    int    popped     = 0;
    bit    model_busy = 1'b0;
    bit    rand_ready = 1'b0;
    bit    stalled    = 1'b0;
    int    prev_data  = 0;
    int    prev_last  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic int ref_coef(input int bank, input int a);
        if (bank == 0) begin
            case (a)
                0: return 502;
                1: return 425;
                2: return 284;
                3: return 36;
                4: return -99;
                default: return 362;
            endcase
        end
        if (bank == 1) return 362;
        return 0;
    endfunction

    function automatic int ref_word(input int bank, input int a, input bit mir);
        int v;
        v = ref_coef(bank, a);
        if (!mir) return v;
        if (v == -1024) return 1023;
        return -v;
    endfunction

    // Called just after a rising edge; start is sampled on the following edge.
    task automatic start_burst(input int bank, input int sa, input int len, input bit mir);
        word_t w;
        start      = 1'b1;
        bank_sel   = 1'(bank);
        start_addr = 4'(sa);
        length     = 5'(len);
        mirror     = mir;
        if (!model_busy && len != 0) begin
            model_busy = 1'b1;
            for (int i = 0; i < len; i++) begin
                w.data = ref_word(bank, (sa + i) % 16, mir);
                w.last = (i == len - 1);
                exp_q.push_back(w);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((model_busy || exp_q.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", int'(model_busy), 0);
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, got_q.size(), ref_list.size());
        for (int i = 0; i < ref_list.size() && i < got_q.size(); i++) begin
            check({name, "_data"}, got_q[i], ref_list[i]);
            check({name, "_last"}, int'(got_last_q[i]), (i == ref_list.size() - 1) ? 1 : 0);
        end
        got_q.delete();
        got_last_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_busy = 1'b0;
            stalled    = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), prev_data);
                check("hold_last", int'(out_last), prev_last);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", int'(out_data), 9999);
                end else begin
                    check("stream_data", int'(out_data), exp_q[0].data);
                    check("stream_last", int'(out_last), int'(exp_q[0].last));
                    if (out_ready) begin
                        got_q.push_back(int'(out_data));
                        got_last_q.push_back(out_last);
                        if (exp_q[0].last) model_busy = 1'b0;
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            stalled   = out_valid && !out_ready;
            prev_data = int'(out_data);
            prev_last = int'(out_last);
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_data_out", int'(data_out), 0);
        rst = 1'b0;

        // Random-access port
        addr = 4'd3;
        @(posedge clk); #1;
        check("ra_addr3", int'(data_out), 36);
        addr = 4'd4;
        @(posedge clk); #1;
        check("ra_addr4", int'(data_out), -99);
        for (int i = 0; i < 10; i++) begin
            a    = $urandom_range(0, 15);
            addr = 4'(a);
            @(posedge clk); #1;
            check("ra_random", int'(data_out), ref_coef(0, a));
        end

        // Basic burst with latency pinning
        got_q.delete();
        got_last_q.delete();
        out_ready = 1'b1;
        start_burst(0, 3, 4, 1'b0);
        check("lat_busy_T", int'(busy), 1);
        check("lat_valid_T", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_valid_T1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_valid_T2", int'(out_valid), 1);
        check("lat_data_T2", int'(out_data), 36);
        wait_idle();
        check("basic_busy_end", int'(busy), 0);
        ref_list = '{36, -99, 362, 362};
        check_got("basic");

        // Mirror with address wrap
        start_burst(0, 15, 3, 1'b1);
        wait_idle();
        ref_list = '{-362, -502, -425};
        check_got("mirror");

        // Directed backpressure: ready low on output cycles 2..4
        start_burst(0, 0, 5, 1'b0);
        for (int c = 0; c < 12; c++) begin
            out_ready = (c < 3 || c > 5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
        ref_list = '{502, 425, 284, 36, -99};
        check_got("bp_fixed");

        // Random backpressure, same burst
        rand_ready = 1'b1;
        start_burst(0, 0, 5, 1'b0);
        wait_idle();
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_got("bp_random");

        // Zero-length request is ignored
        start_burst(0, 5, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("len0_busy", int'(busy), 0);
            @(posedge clk); #1;
        end

        // Start during a burst is ignored
        start_burst(1, 0, 4, 1'b0);
        @(posedge clk); #1;
        start_burst(0, 0, 4, 1'b1);
        wait_idle();
        ref_list = '{362, 362, 362, 362};
        check_got("ignore_start");

        // Reset after the second word of a length-5 burst
        base = popped;
        start_burst(0, 0, 5, 1'b0);
        n = 0;
        while (popped < base + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach", int'(popped >= base + 2), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_last", int'(out_last), 0);
        check("midrst_data", int'(out_data), 0);
        check("midrst_data_out", int'(data_out), 0);
        got_q.delete();
        got_last_q.delete();
        start_burst(1, 0, 2, 1'b0);
        wait_idle();
        ref_list = '{362, 362};
        check_got("post_rst");

        // Randomized bursts against the model under random backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            start_burst($urandom_range(0, 1), $urandom_range(0, 15),
                        $urandom_range(1, 16), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                start_burst($urandom_range(0, 1), $urandom_range(0, 15),
                            $urandom_range(0, 16), 1'($urandom_range(0, 1)));
            end
            wait_idle();
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
